// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: write-port scheduler for the 32x32 register file.
// Shares the single write port between writeback (highest priority) and a
// small FIFO of multi-cycle results, after a post-reset clear sweep of x1..x31.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   wb_we_i/wb_addr_i/wb_data_i        writeback request (never back-pressured)
//   mc_valid_i/mc_addr_i/mc_data_i     multi-cycle result, handshake with mc_ready_o
//   rf_we_o/rf_addr_o/rf_data_o        registered register-file write port
//   stall_o, init_done_o               high during sweep / after sweep
//   pending_o                          one bit per register with a queued write
module regfile_wr_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              mc_valid_i,
  input  logic [ADDR_W-1:0] mc_addr_i,
  input  logic [DATA_W-1:0] mc_data_i,
  output logic              mc_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              stall_o,
  output logic              init_done_o,
  output logic [31:0]       pending_o
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] q_a [DEPTH];
  logic [ADDR_W-1:0] q_a_d [DEPTH];
  logic [DATA_W-1:0] q_d [DEPTH];
  logic [DATA_W-1:0] q_d_d [DEPTH];
  logic [DEPTH-1:0] q_v, q_v_d, surv;
  logic we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic run, wb_win, pop, push;
  int pos [DEPTH];
  int n;
  assign run = state == RUN;
  assign wb_win = run && wb_we_i && wb_addr_i != '0;
  // Valid entries are kept packed at the front, so the last slot being empty means count<DEPTH.
  assign mc_ready_o = run && !q_v[DEPTH-1];
  assign pop = run && !wb_win && q_v[0];
  // Writeback is younger than a result pushed in the same cycle, so a matching push is killed.
  assign push = mc_valid_i && mc_ready_o && mc_addr_i != '0 && !(wb_win && mc_addr_i == wb_addr_i);
  assign stall_o = !run;
  assign init_done_o = run;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    we_d = 1'b0;
    addr_d = rf_addr_o;
    data_d = rf_data_o;
    if (!run) begin
      we_d = 1'b1;
      addr_d = cnt;
      data_d = '0;
      cnt_d = cnt + 1'b1;
      state_d = (cnt == '1) ? RUN : INIT;
    end else if (wb_win) begin
      we_d = 1'b1;
      addr_d = wb_addr_i;
      data_d = wb_data_i;
    end else if (pop) begin
      we_d = 1'b1;
      addr_d = q_a[0];
      data_d = q_d[0];
    end
  end
  // Drop popped/killed entries, compact survivors to the front, then append the push.
  always_comb begin
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      surv[i] = q_v[i] && !(wb_win && q_a[i] == wb_addr_i) && !(pop && i == 0);
      pos[i] = n;
      if (surv[i]) n++;
    end
    for (int j = 0; j < DEPTH; j++) begin
      q_v_d[j] = 1'b0;
      q_a_d[j] = q_a[j];
      q_d_d[j] = q_d[j];
      for (int i = 0; i < DEPTH; i++)
        if (surv[i] && pos[i] == j) begin
          q_v_d[j] = 1'b1;
          q_a_d[j] = q_a[i];
          q_d_d[j] = q_d[i];
        end
      if (push && n == j) begin
        q_v_d[j] = 1'b1;
        q_a_d[j] = mc_addr_i;
        q_d_d[j] = mc_data_i;
      end
    end
  end
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q_v[i]) pending_o[q_a[i]] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= ADDR_W'(1);
      rf_we_o <= 1'b0;
      rf_addr_o <= '0;
      rf_data_o <= '0;
      q_v <= '0;
      q_a <= '{default: '0};
      q_d <= '{default: '0};
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      rf_we_o <= we_d;
      rf_addr_o <= addr_d;
      rf_data_o <= data_d;
      q_v <= q_v_d;
      q_a <= q_a_d;
      q_d <= q_d_d;
    end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: randomized bench against a queue-based reference model.
module tb_regfile_wr_sched;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wb_we = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic mc_valid = 1'b0;
  logic [AW-1:0] mc_addr = '0;
  logic [DW-1:0] mc_data = '0;
  logic mc_ready, rf_we, stall, init_done;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [31:0] pending;

  regfile_wr_sched #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .mc_valid_i(mc_valid), .mc_addr_i(mc_addr), .mc_data_i(mc_data),
    .mc_ready_o(mc_ready),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .stall_o(stall), .init_done_o(init_done), .pending_o(pending)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  ent_t q[$];
  int errors = 0;
  int checks = 0;
  bit run;
  int sweep;
  logic m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit hold;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    run = 0;
    sweep = 1;
    q.delete();
    m_we = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic check_all();
    check("rf_we", 32'(rf_we), 32'(m_we));
    check("rf_addr", 32'(rf_addr), 32'(m_addr));
    check("rf_data", rf_data, m_data);
    check("mc_ready", 32'(mc_ready), 32'(run && q.size() < D));
    check("stall", 32'(stall), 32'(!run));
    check("init_done", 32'(init_done), 32'(run));
    check("pending", pending, m_pend());
  endtask

  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic model_step(output bit acc);
    bit wbw;
    ent_t e;
    acc = 0;
    if (!run) begin
      m_we = 1;
      m_addr = sweep[AW-1:0];
      m_data = '0;
      if (sweep == 31) run = 1;
      sweep++;
    end else begin
      wbw = wb_we && wb_addr != 0;
      acc = mc_valid && q.size() < D;
      if (wbw) begin
        m_we = 1;
        m_addr = wb_addr;
        m_data = wb_data;
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].a == wb_addr) q.delete(i);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1;
        m_addr = e.a;
        m_data = e.d;
      end else m_we = 0;
      if (acc && mc_addr != 0 && !(wbw && mc_addr == wb_addr)) q.push_back('{mc_addr, mc_data});
    end
  endtask

  // Called at a negedge: drive inputs, model the next posedge, check at the following negedge.
  task automatic tick(input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit mv, input int ma, input logic [DW-1:0] md, output bit acc);
    wb_we = we;
    wb_addr = AW'(wa);
    wb_data = wd;
    mc_valid = mv;
    mc_addr = AW'(ma);
    mc_data = md;
    model_step(acc);
    @(negedge clk);
    check_all();
  endtask

  // Random traffic; an offered mc result is held stable until accepted.
  task automatic rnd(input int cycles, input int wbp, input int mcp,
                     input int wlo, input int whi, input int mlo, input int mhi);
    bit acc;
    bit mv;
    for (int c = 0; c < cycles; c++) begin
      if (!hold && $urandom_range(0, 99) < mcp) begin
        hold = 1;
        h_addr = AW'($urandom_range(mlo, mhi));
        h_data = $urandom;
      end
      mv = hold;
      tick($urandom_range(0, 99) < wbp, $urandom_range(wlo, whi), $urandom, mv, int'(h_addr), h_data, acc);
      if (acc) hold = 0;
    end
  endtask

  initial begin
    bit acc;
    hold = 0;
    model_reset();
    #3 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) tick(1, 5, 32'h1111, 1, 6, 32'h2222, acc);
    tick(1, 5, 32'hDEADBEEF, 0, 0, 0, acc);
    tick(1, 0, 32'h12345678, 0, 0, 0, acc);
    tick(0, 0, 0, 1, 7, 32'h1234, acc);
    tick(1, 3, 32'h33, 0, 0, 0, acc);
    tick(1, 4, 32'h44, 0, 0, 0, acc);
    tick(0, 0, 0, 0, 0, 0, acc);
    tick(0, 0, 0, 1, 9, 32'hAAAA, acc);
    tick(1, 9, 32'h5555, 0, 0, 0, acc);
    tick(0, 0, 0, 1, 0, 32'h77, acc);
    tick(0, 0, 0, 0, 0, 0, acc);
    rnd(300, 50, 60, 0, 7, 0, 7);
    rnd(200, 90, 90, 0, 31, 0, 31);
    rnd(6, 100, 100, 1, 3, 16, 31);
    #2 rst_n = 1'b0;
    model_reset();
    hold = 0;
    #1 check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    rnd(300, 40, 50, 0, 7, 0, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
